// File: rtl/rs_issue_arbiter.sv
// Issue arbiter: round-robin pick of one ready reservation-station entry per
// cycle into a registered issue slot with a valid/ready handshake to execute.

package rs_issue_arbiter_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  dest_tag;
    logic [31:0] src1_val;
    logic [31:0] src2_val;
  } res_st_cell_t;

endpackage

module rs_issue_arbiter
  import rs_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_RS = 8,
  parameter int unsigned IDX_W  = $clog2(NUM_RS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RS-1:0]         rs_ready_in,
  input  res_st_cell_t [NUM_RS-1:0] rs_cells_in,
  output logic [NUM_RS-1:0]         issue_grant_out,
  output logic                      exec_valid_out,
  output res_st_cell_t              exec_op_out,
  output logic [IDX_W-1:0]          exec_idx_out,
  input  logic                      exec_ready_in,
  input  logic                      flush_in,
  output logic [31:0]               issued_count_out
);

  typedef enum logic {StEmpty, StFull} slot_state_e;

  slot_state_e      state_q, state_d;
  res_st_cell_t     op_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ptr_q;
  logic [31:0]      count_q;

  logic             load_en;
  logic             accept;
  logic             grant;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;

  // Round-robin search: first ready entry at or after ptr_q, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!grant_any && rs_ready_in[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Slot next-state, handshake qualifiers and one-hot grant.
  always_comb begin
    accept          = (state_q == StFull) & exec_ready_in & ~flush_in;
    load_en         = ~rst & ~flush_in & ((state_q == StEmpty) | exec_ready_in);
    grant           = load_en & grant_any;
    issue_grant_out = '0;
    if (grant) issue_grant_out[grant_idx] = 1'b1;
    state_d = state_q;
    if (flush_in) begin
      state_d = StEmpty;
    end else if (grant) begin
      state_d = StFull;
    end else if (accept) begin
      state_d = StEmpty;
    end
  end

  // Slot state, issue payload, round-robin pointer and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      op_q    <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        op_q  <= rs_cells_in[grant_idx];
        idx_q <= grant_idx;
        ptr_q <= grant_idx + IDX_W'(1);
      end
      if (accept && (count_q != 32'hFFFF_FFFF)) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign exec_valid_out   = (state_q == StFull);
  assign exec_op_out      = op_q;
  assign exec_idx_out     = idx_q;
  assign issued_count_out = count_q;

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Self-checking bench for rs_issue_arbiter: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a model.

module tb_rs_issue_arbiter;
  import rs_issue_arbiter_pkg::*;

  localparam int N = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       rs_ready;
  res_st_cell_t [N-1:0] cells;
  logic [N-1:0]       grant;
  logic               valid;
  res_st_cell_t       op;
  logic [2:0]         idx;
  logic               er;
  logic               fl;
  logic [31:0]        count;

  int checks = 0;
  int fails  = 0;

  // Behavioural model state
  bit           live = 1'b0;
  bit           m_valid = 1'b0;
  res_st_cell_t m_op = '0;
  int           m_idx = 0;
  int           m_ptr = 0;
  logic [31:0]  m_count = '0;

  int           cg;
  logic [N-1:0] ceg;
  int           ug;
  bit           uacc;
  logic [95:0]  rnd;
  res_st_cell_t c3;

  always #5 clk = ~clk;

  rs_issue_arbiter #(.NUM_RS(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .rs_ready_in      (rs_ready),
    .rs_cells_in      (cells),
    .issue_grant_out  (grant),
    .exec_valid_out   (valid),
    .exec_op_out      (op),
    .exec_idx_out     (idx),
    .exec_ready_in    (er),
    .flush_in         (fl),
    .issued_count_out (count)
  );

  // Closest ready entry at or after ptr in circular distance; -1 if none.
  function automatic int pick(input logic [N-1:0] rdy, input int ptr);
    int best  = -1;
    int bestd = N;
    for (int j = 0; j < N; j++) begin
      if (rdy[j] && (((j - ptr + N) % N) < bestd)) begin
        bestd = (j - ptr + N) % N;
        best  = j;
      end
    end
    return best;
  endfunction

  function automatic int model_grant();
    if (rst || fl || (m_valid && !er)) return -1;
    return pick(rs_ready, m_ptr);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle with inputs stable.
  always @(negedge clk) begin
    if (live) begin
      cg  = model_grant();
      ceg = '0;
      if (cg >= 0) ceg[cg] = 1'b1;
      check("model_grant", grant, ceg);
      check("model_valid", valid, m_valid);
      check("model_count", count, m_count);
      if (m_valid) begin
        check("model_idx", idx, m_idx);
        check("model_op", op, m_op);
      end
    end
  end

  // Model state advance at the active edge.
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_op    <= '0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_count <= '0;
    end else begin
      ug   = model_grant();
      uacc = m_valid && er && !fl;
      if (fl) begin
        m_valid <= 1'b0;
      end else if (ug >= 0) begin
        m_valid <= 1'b1;
        m_op    <= cells[ug];
        m_idx   <= ug;
        m_ptr   <= (ug + 1) % N;
      end else if (uacc) begin
        m_valid <= 1'b0;
      end
      if (uacc && (m_count != 32'hFFFF_FFFF)) m_count <= m_count + 32'd1;
    end
  end

  // Drive one cycle of inputs after the edge, return just past mid-cycle.
  task automatic step(input logic r, input logic [N-1:0] rdy, input logic e, input logic f);
    @(posedge clk);
    #1;
    rst      = r;
    rs_ready = rdy;
    er       = e;
    fl       = f;
    for (int i = 0; i < N; i++) begin
      rnd      = {$urandom(), $urandom(), $urandom()};
      cells[i] = rnd[77:0];
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    rs_ready = '0;
    er       = 1'b0;
    fl       = 1'b0;
    cells    = '0;
    step(1'b1, 8'h00, 1'b1, 1'b0);
    live = 1'b1;
    step(1'b1, 8'h00, 1'b1, 1'b0);

    // Reset state
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_grant", grant, 8'h00);
      check("rst_count", count, 32'd0);
    end
    check("rst_op", op, '0);

    // Round-robin between entries 0 and 7
    step(1'b0, 8'h81, 1'b1, 1'b0);
    check("rr_g1", grant, 8'h01);
    step(1'b0, 8'h81, 1'b1, 1'b0);
    check("rr_g2", grant, 8'h80);
    check("rr_i1", idx, 3'd0);
    step(1'b0, 8'h81, 1'b1, 1'b0);
    check("rr_g3", grant, 8'h01);
    check("rr_i2", idx, 3'd7);
    step(1'b0, 8'h81, 1'b1, 1'b0);
    check("rr_g4", grant, 8'h80);
    check("rr_i3", idx, 3'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rr_i4", idx, 3'd7);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rr_count", count, 32'd4);
    check("rr_drain", valid, 1'b0);

    // Backpressure holds entry 3 in the slot
    step(1'b0, 8'h08, 1'b1, 1'b0);
    check("bp_g3", grant, 8'h08);
    c3 = cells[3];
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h30, 1'b0, 1'b0);
      check("bp_nogrant", grant, 8'h00);
      check("bp_op", op, c3);
      check("bp_idx", idx, 3'd3);
    end
    step(1'b0, 8'h30, 1'b1, 1'b0);
    check("bp_release", grant, 8'h10);

    // Wrap from pointer 7
    step(1'b0, 8'h40, 1'b1, 1'b0);
    check("wr_g6", grant, 8'h40);
    step(1'b0, 8'h04, 1'b1, 1'b0);
    check("wr_g2", grant, 8'h04);
    step(1'b0, 8'h0C, 1'b1, 1'b0);
    check("wr_ptr3", grant, 8'h08);

    // Flush beats exec_ready
    step(1'b0, 8'h02, 1'b1, 1'b1);
    check("fl_nogrant", grant, 8'h00);
    check("fl_count", count, 32'd8);
    step(1'b0, 8'h02, 1'b1, 1'b0);
    check("fl_valid", valid, 1'b0);
    check("fl_count2", count, 32'd8);
    check("fl_regrant", grant, 8'h02);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_idx", idx, 3'd1);

    // Saturation, then reset while stalled
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    m_count = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) step(1'b0, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 1'b0);
    check("sat_count", count, 32'hFFFF_FFFF);
    check("stall_nogrant", grant, 8'h00);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("rst_nogrant", grant, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_mid_valid", valid, 1'b0);
    check("rst_mid_count", count, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom()),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
